// File: rtl/control_riesgos.sv
// rtl/control_riesgos.sv - pipeline stall/flush/redirect sequencer for the 5-stage MIPS core
module control_riesgos #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_leer_EX,
    input  logic [4:0]       rt_EX,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic             usa_rt_ID,
    input  logic             salto_EX,
    input  logic             branch_taken_MEM,
    input  logic             mem_leer_MEM,
    input  logic             mem_escribir_MEM,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [1:0]       redirect,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // The first stalled cycle happens in RUN and the release cycle in MEM_WAIT
    // sees a zero counter, so the counter starts two below the latency.
    localparam logic [4:0]       WAIT_INIT = (MEM_LAT > 1) ? 5'(MEM_LAT - 2) : 5'd0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic             MEM_SLOW  = (MEM_LAT > 1);

    state_t           state_q, state_d;
    logic [4:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    logic mem_acc;
    logic load_use;

    assign mem_acc  = mem_leer_MEM | mem_escribir_MEM;
    assign load_use = mem_leer_EX && (rt_EX != 5'd0) &&
                      ((rt_EX == rs_ID) || (usa_rt_ID && (rt_EX == rt_ID)));

    assign stall_count = stall_q;
    assign flush_count = flush_q;

    // Next-state, counter updates and same-cycle pipeline controls
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        stall_d      = stall_q;
        flush_d      = flush_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        redirect     = 2'b00;
        halted       = 1'b0;

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_d      = RUN;
            wait_d       = 5'd0;
            stall_d      = '0;
            flush_d      = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_acc && MEM_SLOW) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_write = 1'b0;
                        wait_d       = WAIT_INIT;
                        state_d      = MEM_WAIT;
                    end else if (branch_taken_MEM) begin
                        redirect     = 2'b10;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
                    end else if (salto_EX) begin
                        redirect    = 2'b01;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        if (flush_q != CNT_MAX) flush_d = flush_q + 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        if (stall_q != CNT_MAX) stall_d = stall_q + 1'b1;
                    end else if (halt_req) begin
                        state_d = HALT;
                    end
                end
                MEM_WAIT: begin
                    if (wait_q != 5'd0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_write = 1'b0;
                        wait_d       = wait_q - 5'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                HALT: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    mem_wb_write = 1'b0;
                    halted       = 1'b1;
                    if (!halt_req) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State, wait counter and performance counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= 5'd0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

endmodule

// File: tb/tb_control_riesgos.sv
// tb/tb_control_riesgos.sv - directed self-checking bench for control_riesgos
module tb_control_riesgos;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_leer_EX;
    logic [4:0]  rt_EX, rs_ID, rt_ID;
    logic        usa_rt_ID, salto_EX, branch_taken_MEM;
    logic        mem_leer_MEM, mem_escribir_MEM, halt_req;

    logic        pw1, ifw1, idw1, exw1, mww1, iff1, idf1, exf1, hl1;
    logic [1:0]  red1;
    logic [15:0] sc1, fc1;
    logic        pw4, ifw4, idw4, exw4, mww4, iff4, idf4, exf4, hl4;
    logic [1:0]  red4;
    logic [15:0] sc4, fc4;

    logic [4:0]  en1, en4;
    logic [2:0]  fl1, fl4;
    assign en1 = {pw1, ifw1, idw1, exw1, mww1};
    assign en4 = {pw4, ifw4, idw4, exw4, mww4};
    assign fl1 = {iff1, idf1, exf1};
    assign fl4 = {iff4, idf4, exf4};

    integer n_checks = 0;
    integer n_fail   = 0;

    always #5 clk = ~clk;

    control_riesgos #(.MEM_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .mem_leer_EX(mem_leer_EX), .rt_EX(rt_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .usa_rt_ID(usa_rt_ID), .salto_EX(salto_EX),
        .branch_taken_MEM(branch_taken_MEM), .mem_leer_MEM(mem_leer_MEM),
        .mem_escribir_MEM(mem_escribir_MEM), .halt_req(halt_req),
        .pc_write(pw1), .if_id_write(ifw1), .id_ex_write(idw1), .ex_mem_write(exw1),
        .mem_wb_write(mww1), .if_id_flush(iff1), .id_ex_flush(idf1), .ex_mem_flush(exf1),
        .redirect(red1), .halted(hl1), .stall_count(sc1), .flush_count(fc1)
    );

    control_riesgos #(.MEM_LAT(4), .CNT_W(16)) dut4 (
        .clk(clk), .reset(reset), .mem_leer_EX(mem_leer_EX), .rt_EX(rt_EX),
        .rs_ID(rs_ID), .rt_ID(rt_ID), .usa_rt_ID(usa_rt_ID), .salto_EX(salto_EX),
        .branch_taken_MEM(branch_taken_MEM), .mem_leer_MEM(mem_leer_MEM),
        .mem_escribir_MEM(mem_escribir_MEM), .halt_req(halt_req),
        .pc_write(pw4), .if_id_write(ifw4), .id_ex_write(idw4), .ex_mem_write(exw4),
        .mem_wb_write(mww4), .if_id_flush(iff4), .id_ex_flush(idf4), .ex_mem_flush(exf4),
        .redirect(red4), .halted(hl4), .stall_count(sc4), .flush_count(fc4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_leer_EX = 0; rt_EX = 0; rs_ID = 0; rt_ID = 0; usa_rt_ID = 0;
        salto_EX = 0; branch_taken_MEM = 0; mem_leer_MEM = 0; mem_escribir_MEM = 0;
        halt_req = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        #1;
        n_checks++; if (en1 !== 5'b00000) begin n_fail++; $display("FAIL rst_en got %b exp %b", en1, 5'b00000); end
        n_checks++; if ({fl1, red1, hl1} !== 6'b0) begin n_fail++; $display("FAIL rst_fl_red_halt got %b exp 0", {fl1, red1, hl1}); end
        cyc(); cyc();
        reset = 0;
        #1;
        n_checks++; if (en1 !== 5'b11111) begin n_fail++; $display("FAIL idle_en got %b exp %b", en1, 5'b11111); end
        n_checks++; if ({fl1, red1, hl1} !== 6'b0) begin n_fail++; $display("FAIL idle_fl_red_halt got %b exp 0", {fl1, red1, hl1}); end
        n_checks++; if (sc1 !== 16'd0 || fc1 !== 16'd0) begin n_fail++; $display("FAIL idle_counts got %0d/%0d exp 0/0", sc1, fc1); end
        n_checks++; if (en4 !== 5'b11111) begin n_fail++; $display("FAIL idle_en4 got %b exp %b", en4, 5'b11111); end
    endtask

    task automatic test_load_use();
        mem_leer_EX = 1; rt_EX = 5; rs_ID = 5;
        #1;
        n_checks++; if (en1 !== 5'b00111) begin n_fail++; $display("FAIL lu_en got %b exp %b", en1, 5'b00111); end
        n_checks++; if (fl1 !== 3'b010) begin n_fail++; $display("FAIL lu_fl got %b exp %b", fl1, 3'b010); end
        cyc(); idle(); #1;
        n_checks++; if (sc1 !== 16'd1) begin n_fail++; $display("FAIL lu_count got %0d exp 1", sc1); end
        mem_leer_EX = 1; rt_EX = 0; rs_ID = 0;
        #1;
        n_checks++; if (en1 !== 5'b11111 || fl1 !== 3'b000) begin n_fail++; $display("FAIL lu_r0 got en %b fl %b exp 11111 000", en1, fl1); end
        cyc(); idle();
        mem_leer_EX = 1; rt_EX = 7; rs_ID = 3; rt_ID = 7; usa_rt_ID = 0;
        #1;
        n_checks++; if (en1 !== 5'b11111) begin n_fail++; $display("FAIL lu_rt_unused got %b exp %b", en1, 5'b11111); end
        usa_rt_ID = 1;
        #1;
        n_checks++; if (en1 !== 5'b00111 || fl1 !== 3'b010) begin n_fail++; $display("FAIL lu_rt got en %b fl %b exp 00111 010", en1, fl1); end
        cyc(); idle(); #1;
        n_checks++; if (sc1 !== 16'd2) begin n_fail++; $display("FAIL lu_count2 got %0d exp 2", sc1); end
    endtask

    task automatic test_branch_jump();
        salto_EX = 1; branch_taken_MEM = 1;
        #1;
        n_checks++; if (red1 !== 2'b10) begin n_fail++; $display("FAIL bj_red got %b exp %b", red1, 2'b10); end
        n_checks++; if (fl1 !== 3'b111 || en1 !== 5'b11111) begin n_fail++; $display("FAIL bj_fl_en got %b %b exp 111 11111", fl1, en1); end
        cyc(); idle(); #1;
        n_checks++; if (fc1 !== 16'd1) begin n_fail++; $display("FAIL bj_count got %0d exp 1", fc1); end
        salto_EX = 1;
        #1;
        n_checks++; if (red1 !== 2'b01 || fl1 !== 3'b110) begin n_fail++; $display("FAIL j_red_fl got %b %b exp 01 110", red1, fl1); end
        cyc(); idle();
        salto_EX = 1; mem_leer_EX = 1; rt_EX = 9; rs_ID = 9;
        #1;
        n_checks++; if (red1 !== 2'b01 || en1 !== 5'b11111) begin n_fail++; $display("FAIL j_over_lu got %b %b exp 01 11111", red1, en1); end
        cyc(); idle(); #1;
        n_checks++; if (fc1 !== 16'd3 || sc1 !== 16'd2) begin n_fail++; $display("FAIL j_counts got %0d/%0d exp 3/2", fc1, sc1); end
    endtask

    task automatic test_mem_wait();
        mem_leer_MEM = 1;
        #1;
        n_checks++; if (en4 !== 5'b00000) begin n_fail++; $display("FAIL mw_c1 got %b exp 00000", en4); end
        n_checks++; if (en1 !== 5'b11111) begin n_fail++; $display("FAIL mw_lat1 got %b exp 11111", en1); end
        cyc();
        branch_taken_MEM = 1;
        #1;
        n_checks++; if (en4 !== 5'b00000 || red4 !== 2'b00 || fl4 !== 3'b000) begin n_fail++; $display("FAIL mw_c2 got %b %b %b exp 00000 00 000", en4, red4, fl4); end
        cyc();
        branch_taken_MEM = 0;
        #1;
        n_checks++; if (en4 !== 5'b00000) begin n_fail++; $display("FAIL mw_c3 got %b exp 00000", en4); end
        cyc(); #1;
        n_checks++; if (en4 !== 5'b11111) begin n_fail++; $display("FAIL mw_c4 got %b exp 11111", en4); end
        cyc(); idle(); #1;
        n_checks++; if (en4 !== 5'b11111) begin n_fail++; $display("FAIL mw_after got %b exp 11111", en4); end
        n_checks++; if (fc4 !== 16'd3 || fc1 !== 16'd4) begin n_fail++; $display("FAIL mw_counts got %0d/%0d exp 3/4", fc4, fc1); end
        mem_escribir_MEM = 1;
        cyc(); idle();
        reset = 1;
        cyc();
        reset = 0;
        #1;
        n_checks++; if (en4 !== 5'b11111 || fc4 !== 16'd0) begin n_fail++; $display("FAIL mw_reset got %b %0d exp 11111 0", en4, fc4); end
    endtask

    task automatic test_halt();
        halt_req = 1;
        #1;
        n_checks++; if (en1 !== 5'b11111 || hl1 !== 1'b0) begin n_fail++; $display("FAIL h_first got %b %b exp 11111 0", en1, hl1); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++; if (en1 !== 5'b00000 || hl1 !== 1'b1) begin n_fail++; $display("FAIL h_hold%0d got %b %b exp 00000 1", i, en1, hl1); end
        end
        cyc();
        halt_req = 0;
        #1;
        n_checks++; if (en1 !== 5'b00000 || hl1 !== 1'b1) begin n_fail++; $display("FAIL h_drop got %b %b exp 00000 1", en1, hl1); end
        cyc();
        n_checks++; if (en1 !== 5'b11111 || hl1 !== 1'b0) begin n_fail++; $display("FAIL h_resume got %b %b exp 11111 0", en1, hl1); end
        halt_req = 1;
        cyc();
        n_checks++; if (hl4 !== 1'b1) begin n_fail++; $display("FAIL h_again got %b exp 1", hl4); end
        reset = 1;
        cyc();
        reset = 0; halt_req = 0;
        #1;
        n_checks++; if (hl1 !== 1'b0 || en1 !== 5'b11111) begin n_fail++; $display("FAIL h_reset got %b %b exp 0 11111", hl1, en1); end
    endtask

    task automatic test_saturation();
        mem_leer_EX = 1; rt_EX = 4; rs_ID = 4;
        for (int i = 0; i < 65535; i++) cyc();
        n_checks++; if (sc1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %h exp ffff", sc1); end
        for (int i = 0; i < 5; i++) cyc();
        n_checks++; if (sc1 !== 16'hFFFF || sc4 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h/%h exp ffff/ffff", sc1, sc4); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_jump();
        test_mem_wait();
        test_halt();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
